// File: rtl/nla_fp_pkg.sv
// Shared FP32 constants and types for the NonLinearApprox FP datapath.
package nla_fp_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_MAN_W  = 23;
    localparam int unsigned TAG_W_DEF = 4;

    localparam logic [FP_W-1:0] FP32_ONE   = 32'h3F800000;
    localparam logic [FP_W-1:0] FP32_TWO   = 32'h40000000;
    localparam logic [FP_W-1:0] FP32_THREE = 32'h40400000;
    localparam logic [FP_W-1:0] FP32_QNAN  = 32'h7FC00000;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_mode_e;

endpackage

// File: rtl/Addsub_32.sv
// Combinational FP32 add/subtract, round-to-nearest-even; subnormals flush to zero.
module Addsub_32
    import nla_fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mode,
    output logic [31:0] result
);

    logic              sb_eff, swap, sl, ss, rnd;
    logic              a_nan, b_nan, a_inf, b_inf;
    logic [30:0]       xl, xs;
    logic [7:0]        el, es, d;
    logic [23:0]       ml, ms;
    logic [49:0]       ms_w;
    logic [26:0]       al_s, norm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e_n;
    logic [24:0]       mant;
    logic [22:0]       frac;

    always_comb begin
        sb_eff = b[31] ^ (mode == OP_SUB);
        a_nan  = (&a[30:23]) & (|a[22:0]);
        b_nan  = (&b[30:23]) & (|b[22:0]);
        a_inf  = (&a[30:23]) & ~(|a[22:0]);
        b_inf  = (&b[30:23]) & ~(|b[22:0]);

        swap = b[30:0] > a[30:0];
        sl   = swap ? sb_eff : a[31];
        ss   = swap ? a[31] : sb_eff;
        xl   = swap ? b[30:0] : a[30:0];
        xs   = swap ? a[30:0] : b[30:0];
        el   = xl[30:23];
        es   = xs[30:23];
        ml   = (el == 8'd0) ? '0 : {1'b1, xl[22:0]};
        ms   = (es == 8'd0) ? '0 : {1'b1, xs[22:0]};
        d    = el - es;

        // Align the smaller operand keeping guard, round and a sticky bit
        ms_w = {ms, 26'b0} >> d;
        al_s = (d > 8'd49) ? {26'b0, |ms} : {ms_w[49:24], |ms_w[23:0]};
        sum  = (sl == ss) ? ({1'b0, ml, 3'b0} + {1'b0, al_s})
                          : ({1'b0, ml, 3'b0} - {1'b0, al_s});

        lz = '0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end

        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e_n  = $signed({2'b0, el}) + 10'sd1;
        end else begin
            norm = sum[26:0] << lz;
            e_n  = $signed({2'b0, el}) - $signed({5'b0, lz});
        end

        rnd  = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant = {1'b0, norm[26:3]} + {24'b0, rnd};
        frac = mant[24] ? mant[23:1] : mant[22:0];
        if (mant[24]) e_n = e_n + 10'sd1;

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb_eff))) begin
            result = FP32_QNAN;
        end else if (a_inf) begin
            result = {a[31], 8'hFF, 23'b0};
        end else if (b_inf) begin
            result = {sb_eff, 8'hFF, 23'b0};
        end else if (sum == '0) begin
            result = {sl & ss, 31'b0};
        end else if (e_n >= 10'sd255) begin
            result = {sl, 8'hFF, 23'b0};
        end else if (e_n <= 10'sd0) begin
            result = {sl, 31'b0};
        end else begin
            result = {sl, e_n[7:0], frac};
        end
    end

endmodule

// File: rtl/fp_rr_arbiter.sv
// Round-robin one-hot arbiter; owns the rotating priority pointer.
module fp_rr_arbiter #(
    parameter int unsigned  N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] ptr_q, ptr_d, idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        ptr_d     = ptr_q;
        idx       = '0;
        any       = |req;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((32'(ptr_q) + k) % N);
            if (en && !rst && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                ptr_d      = IW'((32'(idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one Addsub_32 among NUM_REQ requesters: RR grant -> S1 operands -> S2 result.
module fp_addsub_arbiter
    import nla_fp_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 4,
    parameter int unsigned  WIDTH   = FP_W,
    parameter int unsigned  TAG_W   = TAG_W_DEF,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_n,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_mode,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [WIDTH-1:0]         rsp_result
);

    logic             s1_en, s2_en, any_req;
    logic [ID_W-1:0]  gidx;
    logic [WIDTH-1:0] s1_res;

    logic             s1_valid_q, s1_mode_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [ID_W-1:0]  s1_id_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_res_q;
    logic [ID_W-1:0]  s2_id_q;
    logic [TAG_W-1:0] s2_tag_q;

    assign s2_en = !s2_valid_q || rsp_ready;
    assign s1_en = !s1_valid_q || s2_en;

    fp_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk_n),
        .rst       (rst_n),
        .req       (req_valid),
        .en        (s1_en),
        .grant     (req_ready),
        .grant_idx (gidx),
        .any       (any_req)
    );

    Addsub_32 u_addsub (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .mode   (s1_mode_q),
        .result (s1_res)
    );

    always_ff @(posedge clk_n) begin
        if (rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s1_tag_q   <= '0;
        end else if (s1_en) begin
            s1_valid_q <= any_req;
            if (any_req) begin
                s1_mode_q <= req_mode[gidx];
                s1_a_q    <= req_a[32'(gidx)*WIDTH +: WIDTH];
                s1_b_q    <= req_b[32'(gidx)*WIDTH +: WIDTH];
                s1_id_q   <= gidx;
                s1_tag_q  <= req_tag[32'(gidx)*TAG_W +: TAG_W];
            end
        end
    end

    // Payload only updates on a real transfer so idle outputs stay quiet
    always_ff @(posedge clk_n) begin
        if (rst_n) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_id_q    <= '0;
            s2_tag_q   <= '0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q <= s1_res;
                s2_id_q  <= s1_id_q;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    assign rsp_valid  = s2_valid_q;
    assign rsp_id     = s2_id_q;
    assign rsp_tag    = s2_tag_q;
    assign rsp_result = s2_res_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench: scoreboard built from real arithmetic and an abstract queue model.
module tb_fp_addsub_arbiter;
    import nla_fp_pkg::*;

    localparam int N = 4, W = 32, TW = 4, IDW = 2;

    logic              clk_n = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      req_valid, req_ready, req_mode;
    logic [N*W-1:0]    req_a, req_b;
    logic [N*TW-1:0]   req_tag;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [TW-1:0]     rsp_tag;
    logic [W-1:0]      rsp_result;

    fp_addsub_arbiter #(.NUM_REQ(N), .WIDTH(W), .TAG_W(TW)) dut (
        .clk_n(clk_n), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_result(rsp_result)
    );

    always #5 clk_n = ~clk_n;

    typedef struct {
        int            id;
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        int            age;
    } item_t;

    item_t          mq[$];
    int             mptr, exp_grant, errors, checks;
    logic [N-1:0]   obs_ready, exp_ready;
    logic           obs_rv, exp_rv;
    logic [IDW-1:0] obs_id, exp_id;
    logic [TW-1:0]  obs_tag, exp_tag;
    logic [W-1:0]   obs_res, exp_res;

    function automatic real f2r(input logic [31:0] a);
        logic [10:0] e11;
        if (a[30:0] == '0) return $bitstoreal({a[31], 63'b0});
        e11 = {3'b0, a[30:23]} + 11'd896;
        return $bitstoreal({a[31], e11, a[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] bits;
        logic [24:0] m;
        int          e;
        bits = $realtobits(r);
        if (bits[62:0] == '0) return {bits[63], 31'b0};
        e = int'(bits[62:52]) - 896;
        m = {2'b01, bits[51:29]};
        if (bits[28] && ((|bits[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        return {bits[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] ref_addsub(input logic [31:0] a, input logic [31:0] b, input logic m);
        real x, y;
        x = f2r(a);
        y = f2r(b);
        return r2f(m ? (x - y) : (x + y));
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, input logic [TW-1:0] t);
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
        req_mode[i]        = m;
        req_tag[i*TW +: TW] = t;
    endtask

    task automatic new_op(input int i);
        logic [W-1:0] a;
        a = rand_fp();
        set_op(i, a, ($urandom_range(0, 7) == 0) ? a : rand_fp(), 1'($urandom_range(0, 1)), 4'($urandom));
    endtask

    task automatic sample();
        #1;
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_id    = rsp_id;
        obs_tag   = rsp_tag;
        obs_res   = rsp_result;
        exp_grant = -1;
        if (!rst_n && !(mq.size() == 2 && !rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                if (exp_grant < 0 && req_valid[(mptr + k) % N]) exp_grant = (mptr + k) % N;
            end
        end
        exp_ready = '0;
        if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
        exp_rv  = (mq.size() > 0) && (mq[0].age >= 1);
        exp_id  = '0;
        exp_tag = '0;
        exp_res = '0;
        if (exp_rv) begin
            exp_id  = IDW'(mq[0].id);
            exp_tag = mq[0].tag;
            exp_res = mq[0].res;
        end
    endtask

    task automatic tick();
        item_t it;
        @(posedge clk_n);
        if (rst_n) begin
            mq.delete();
            mptr = 0;
        end else begin
            if (exp_rv && rsp_ready) void'(mq.pop_front());
            foreach (mq[j]) mq[j].age = mq[j].age + 1;
            if (exp_grant >= 0) begin
                it.id  = exp_grant;
                it.tag = req_tag[exp_grant*TW +: TW];
                it.res = ref_addsub(req_a[exp_grant*W +: W], req_b[exp_grant*W +: W], req_mode[exp_grant]);
                it.age = 0;
                mq.push_back(it);
                mptr = (exp_grant + 1) % N;
            end
        end
        @(negedge clk_n);
    endtask

    task automatic do_reset();
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) begin
            sample();
            tick();
        end
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) new_op(i);
        req_valid = '1;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        repeat (3) begin
            sample();
            checks++;
            if (obs_ready !== '0) begin
                errors++;
                $display("FAIL reset_ready: got %b expected 0000", obs_ready);
            end
            tick();
        end
        rst_n     = 1'b0;
        req_valid = '0;
        sample();
        checks++;
        if ({obs_rv, obs_id, obs_tag, obs_res} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b id=%0d tag=%h res=%h expected all zero", obs_rv, obs_id, obs_tag, obs_res);
        end
        checks++;
        if (dut.u_arb.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_ptr: got %0d expected 0", dut.u_arb.ptr_q);
        end
        tick();
    endtask

    task automatic test_single_op();
        do_reset();
        rsp_ready = 1'b1;
        set_op(0, FP32_ONE, FP32_TWO, OP_ADD, 4'd5);
        req_valid = 4'b0001;
        sample();
        checks++;
        if (obs_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b expected 0001", obs_ready);
        end
        tick();
        req_valid = '0;
        sample();
        checks++;
        if (obs_rv !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got rsp_valid=%b expected 0", obs_rv);
        end
        tick();
        sample();
        checks++;
        if ({obs_rv, obs_id, obs_tag, obs_res} !== {1'b1, 2'd0, 4'd5, FP32_THREE}) begin
            errors++;
            $display("FAIL single_rsp: got v=%b id=%0d tag=%0d res=%h expected v=1 id=0 tag=5 res=%h",
                     obs_rv, obs_id, obs_tag, obs_res, FP32_THREE);
        end
        tick();
        sample();
        checks++;
        if (obs_rv !== 1'b0) begin
            errors++;
            $display("FAIL single_dup: got rsp_valid=%b expected 0", obs_rv);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) new_op(i);
        req_valid = '1;
        for (int c = 0; c < 16; c++) begin
            sample();
            want = '0;
            want[c % N] = 1'b1;
            checks++;
            if (obs_ready !== want) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got %b expected %b", c, obs_ready, want);
            end
            if (c >= 2) begin
                checks++;
                if (obs_rv !== 1'b1 || obs_id !== IDW'((c - 2) % N)) begin
                    errors++;
                    $display("FAIL fair_rsp_id[%0d]: got v=%b id=%0d expected v=1 id=%0d", c, obs_rv, obs_id, (c - 2) % N);
                end
                checks++;
                if ({obs_tag, obs_res} !== {exp_tag, exp_res}) begin
                    errors++;
                    $display("FAIL fair_payload[%0d]: got tag=%h res=%h expected tag=%h res=%h", c, obs_tag, obs_res, exp_tag, exp_res);
                end
            end
            tick();
            if (exp_grant >= 0) new_op(exp_grant);
        end
        req_valid = '0;
        repeat (3) begin
            sample();
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_res;
        int           grants_n, rsps_n;
        do_reset();
        grants_n  = 0;
        rsps_n    = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) new_op(i);
        req_valid = '1;
        repeat (2) begin
            sample();
            if (obs_ready != '0) grants_n++;
            tick();
            if (exp_grant >= 0) new_op(exp_grant);
        end
        rsp_ready = 1'b0;
        held_res  = rsp_result;
        repeat (4) begin
            sample();
            checks++;
            if (obs_ready !== '0) begin
                errors++;
                $display("FAIL bp_stall_ready: got %b expected 0000", obs_ready);
            end
            checks++;
            if ({obs_rv, obs_id, obs_tag, obs_res} !== {1'b1, exp_id, exp_tag, exp_res} || obs_res !== held_res) begin
                errors++;
                $display("FAIL bp_hold: got v=%b id=%0d tag=%h res=%h expected v=1 id=%0d tag=%h res=%h",
                         obs_rv, obs_id, obs_tag, obs_res, exp_id, exp_tag, exp_res);
            end
            tick();
        end
        rsp_ready = 1'b1;
        sample();
        checks++;
        if (obs_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_grant: got %b expected 0100", obs_ready);
        end
        if (obs_ready != '0) grants_n++;
        if (obs_rv) rsps_n++;
        tick();
        if (exp_grant >= 0) new_op(exp_grant);
        for (int c = 0; c < 14; c++) begin
            if (c == 8) req_valid = '0;
            rsp_ready = (c >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
            sample();
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b expected %b", c, obs_ready, exp_ready);
            end
            checks++;
            if ({obs_rv, obs_id, obs_tag, obs_res} !== {exp_rv, exp_id, exp_tag, exp_res} && (exp_rv || obs_rv)) begin
                errors++;
                $display("FAIL bp_rsp[%0d]: got v=%b id=%0d tag=%h res=%h expected v=%b id=%0d tag=%h res=%h",
                         c, obs_rv, obs_id, obs_tag, obs_res, exp_rv, exp_id, exp_tag, exp_res);
            end
            if (obs_ready != '0) grants_n++;
            if (obs_rv && rsp_ready) rsps_n++;
            tick();
            if (exp_grant >= 0) new_op(exp_grant);
        end
        checks++;
        if (rsps_n !== grants_n) begin
            errors++;
            $display("FAIL bp_count: got %0d responses expected %0d", rsps_n, grants_n);
        end
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        rsp_ready = 1'b1;
        new_op(2);
        req_valid = 4'b0100;
        sample();
        tick();
        req_valid = '0;
        checks++;
        if (dut.u_arb.ptr_q !== 2'd3) begin
            errors++;
            $display("FAIL wrap_ptr_start: got %0d expected 3", dut.u_arb.ptr_q);
        end
        new_op(1);
        new_op(3);
        req_valid = 4'b1010;
        sample();
        checks++;
        if (obs_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_grant3: got %b expected 1000", obs_ready);
        end
        tick();
        req_valid[3] = 1'b0;
        checks++;
        if (dut.u_arb.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL wrap_ptr0: got %0d expected 0", dut.u_arb.ptr_q);
        end
        sample();
        checks++;
        if (obs_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_grant1: got %b expected 0010", obs_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (dut.u_arb.ptr_q !== 2'd2) begin
            errors++;
            $display("FAIL wrap_ptr2: got %0d expected 2", dut.u_arb.ptr_q);
        end
        repeat (3) begin
            sample();
            checks++;
            if ({obs_rv, obs_id, obs_tag, obs_res} !== {exp_rv, exp_id, exp_tag, exp_res} && (exp_rv || obs_rv)) begin
                errors++;
                $display("FAIL wrap_rsp: got v=%b id=%0d res=%h expected v=%b id=%0d res=%h",
                         obs_rv, obs_id, obs_res, exp_rv, exp_id, exp_res);
            end
            tick();
        end
    endtask

    task automatic test_mode();
        logic [W-1:0] want [2];
        int           seen;
        want[0] = FP32_TWO;
        want[1] = 32'h0000_0000;
        rsp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            set_op(2, FP32_THREE, (t == 0) ? FP32_ONE : FP32_THREE, OP_SUB, 4'd9);
            req_valid = 4'b0100;
            sample();
            tick();
            req_valid = '0;
            seen = 0;
            for (int c = 0; c < 4 && seen == 0; c++) begin
                sample();
                if (obs_rv) begin
                    seen = 1;
                    checks++;
                    if (obs_res !== want[t] || obs_id !== 2'd2) begin
                        errors++;
                        $display("FAIL mode_sub[%0d]: got id=%0d res=%h expected id=2 res=%h", t, obs_id, obs_res, want[t]);
                    end
                end
                tick();
            end
            if (seen == 0) begin
                checks++;
                errors++;
                $display("FAIL mode_timeout[%0d]: got no response expected one within 4 cycles", t);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    new_op(i);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            sample();
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: got %b expected %b", c, obs_ready, exp_ready);
            end
            checks++;
            if (obs_rv !== exp_rv) begin
                errors++;
                $display("FAIL rnd_valid[%0d]: got %b expected %b", c, obs_rv, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if ({obs_id, obs_tag, obs_res} !== {exp_id, exp_tag, exp_res}) begin
                    errors++;
                    $display("FAIL rnd_payload[%0d]: got id=%0d tag=%h res=%h expected id=%0d tag=%h res=%h",
                             c, obs_id, obs_tag, obs_res, exp_id, exp_tag, exp_res);
                end
            end
            tick();
            if (exp_grant >= 0) req_valid[exp_grant] = 1'b0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) begin
            sample();
            tick();
        end
        sample();
        checks++;
        if (obs_rv !== 1'b0) begin
            errors++;
            $display("FAIL rnd_drain: got rsp_valid=%b expected 0", obs_rv);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < N; i++) new_op(i);
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (2) begin
            sample();
            tick();
            if (exp_grant >= 0) new_op(exp_grant);
        end
        sample();
        checks++;
        if (obs_rv !== 1'b1 || obs_ready !== '0) begin
            errors++;
            $display("FAIL mid_full: got v=%b ready=%b expected v=1 ready=0000", obs_rv, obs_ready);
        end
        tick();
        rst_n     = 1'b1;
        req_valid = '0;
        sample();
        tick();
        rst_n = 1'b0;
        sample();
        checks++;
        if (obs_rv !== 1'b0 || dut.u_arb.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b ptr=%0d expected v=0 ptr=0", obs_rv, dut.u_arb.ptr_q);
        end
        tick();
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++;
            if (obs_rv !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale[%0d]: got rsp_valid=1 id=%0d expected 0", c, obs_id);
            end
            tick();
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        mptr      = 0;
        exp_grant = -1;
        req_valid = '0;
        req_mode  = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        @(negedge clk_n);
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_sparse_wrap();
        test_mode();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
